// File: rtl/instruction_fetch.sv
// instruction_fetch: PC register and IF/ID pipeline register; IF_PERF_CNT_EN adds fetch/stall counters
module instruction_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
`ifdef IF_PERF_CNT_EN
    output logic [31:0] fetch_cnt,
    output logic [31:0] stall_cnt,
`endif
    output logic [31:0] im_addr,
    input  logic [31:0] im_data,
    input  logic        stall,
    input  logic        flush,
    input  logic        pc_src,
    input  logic [31:0] pc_target,
    output logic [31:0] pc,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc_plus4,
    output logic        ifid_valid
);
    logic [31:0] pc_plus4;
    assign pc_plus4 = pc + 32'd4;
    assign im_addr  = pc;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pc <= RESET_PC;
        else if (pc_src)
            pc <= {pc_target[31:2], 2'b00};
        else if (!stall)
            pc <= pc_plus4;
    end
    // flush outranks stall so a killed slot never survives a hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ifid_instr    <= NOP_INSTR;
            ifid_pc_plus4 <= 32'd0;
            ifid_valid    <= 1'b0;
        end else if (flush) begin
            ifid_instr    <= NOP_INSTR;
            ifid_pc_plus4 <= 32'd0;
            ifid_valid    <= 1'b0;
        end else if (!stall) begin
            ifid_instr    <= im_data;
            ifid_pc_plus4 <= pc_plus4;
            ifid_valid    <= 1'b1;
        end
    end
`ifdef IF_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt <= 32'd0;
            stall_cnt <= 32'd0;
        end else if (!flush) begin
            fetch_cnt <= stall ? fetch_cnt : fetch_cnt + 32'd1;
            stall_cnt <= stall ? stall_cnt + 32'd1 : stall_cnt;
        end
    end
`endif
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: scoreboard bench for instruction_fetch
module tb_instruction_fetch;
    logic        clk = 1'b0, rst_n = 1'b0, stall = 1'b0, flush = 1'b0, pc_src = 1'b0;
    logic [31:0] pc_target = 32'd0;
    logic [31:0] im_addr, im_data, pc, ifid_instr, ifid_pc_plus4;
    logic        ifid_valid;
`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt, stall_cnt;
`endif
    int total = 0, bad = 0;
    logic [31:0] mem [0:1023];
    assign im_data = mem[im_addr[11:2]];
    always #5 clk = ~clk;

    instruction_fetch dut (
        .clk(clk), .rst_n(rst_n),
`ifdef IF_PERF_CNT_EN
        .fetch_cnt(fetch_cnt), .stall_cnt(stall_cnt),
`endif
        .im_addr(im_addr), .im_data(im_data), .stall(stall), .flush(flush),
        .pc_src(pc_src), .pc_target(pc_target), .pc(pc), .ifid_instr(ifid_instr),
        .ifid_pc_plus4(ifid_pc_plus4), .ifid_valid(ifid_valid)
    );

    typedef struct {
        logic [31:0] pc, instr, pc4;
        logic        valid;
        logic [31:0] fc, sc;
    } exp_t;
    exp_t q[$];
    exp_t me;
    logic [31:0] m_pc, m_instr, m_pc4, m_fc, m_sc;
    logic        m_valid;

    always @(posedge clk) begin
        #1;
        if (q.size() != 0) begin
            me = q.pop_front();
            total += 5;
            if (pc !== me.pc) begin bad++; $display("FAIL sb_pc got %h want %h", pc, me.pc); end
            if (im_addr !== me.pc) begin bad++; $display("FAIL sb_im_addr got %h want %h", im_addr, me.pc); end
            if (ifid_instr !== me.instr) begin bad++; $display("FAIL sb_instr got %h want %h", ifid_instr, me.instr); end
            if (ifid_pc_plus4 !== me.pc4) begin bad++; $display("FAIL sb_pc4 got %h want %h", ifid_pc_plus4, me.pc4); end
            if (ifid_valid !== me.valid) begin bad++; $display("FAIL sb_valid got %b want %b", ifid_valid, me.valid); end
`ifdef IF_PERF_CNT_EN
            total += 2;
            if (fetch_cnt !== me.fc) begin bad++; $display("FAIL sb_fetch_cnt got %0d want %0d", fetch_cnt, me.fc); end
            if (stall_cnt !== me.sc) begin bad++; $display("FAIL sb_stall_cnt got %0d want %0d", stall_cnt, me.sc); end
`endif
        end
    end

    task automatic model_reset();
        m_pc = 32'd0; m_instr = 32'd0; m_pc4 = 32'd0; m_valid = 1'b0; m_fc = 32'd0; m_sc = 32'd0;
    endtask

    task automatic step(input logic s, input logic f, input logic ps, input logic [31:0] t);
        exp_t e;
        logic [31:0] w, p4;
        w  = mem[m_pc[11:2]];
        p4 = m_pc + 32'd4;
        if (f) begin
            m_instr = 32'd0; m_pc4 = 32'd0; m_valid = 1'b0;
        end else if (!s) begin
            m_instr = w; m_pc4 = p4; m_valid = 1'b1; m_fc++;
        end else
            m_sc++;
        m_pc = ps ? {t[31:2], 2'b00} : (s ? m_pc : p4);
        e = '{m_pc, m_instr, m_pc4, m_valid, m_fc, m_sc};
        q.push_back(e);
        stall = s; flush = f; pc_src = ps; pc_target = t;
        @(posedge clk);
        #1;
        stall = 1'b0; flush = 1'b0; pc_src = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; stall = 1'b1; pc_src = 1'b1; pc_target = 32'h0000_0100;
        #3;
        total += 5;
        if (pc !== 32'd0) begin bad++; $display("FAIL rst_pc got %h want %h", pc, 32'd0); end
        if (im_addr !== 32'd0) begin bad++; $display("FAIL rst_im_addr got %h want %h", im_addr, 32'd0); end
        if (ifid_instr !== 32'd0) begin bad++; $display("FAIL rst_instr got %h want %h", ifid_instr, 32'd0); end
        if (ifid_pc_plus4 !== 32'd0) begin bad++; $display("FAIL rst_pc4 got %h want %h", ifid_pc_plus4, 32'd0); end
        if (ifid_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got %b want 0", ifid_valid); end
        @(posedge clk);
        stall = 1'b0; pc_src = 1'b0; pc_target = 32'd0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_free_run();
        step(0, 0, 0, 0);
        total += 3;
        if (ifid_instr !== 32'hAD0A_0008) begin bad++; $display("FAIL fr_instr0 got %h want %h", ifid_instr, 32'hAD0A_0008); end
        if (ifid_pc_plus4 !== 32'd4) begin bad++; $display("FAIL fr_pc4_0 got %h want %h", ifid_pc_plus4, 32'd4); end
        if (ifid_valid !== 1'b1) begin bad++; $display("FAIL fr_valid got %b want 1", ifid_valid); end
        step(0, 0, 0, 0);
        total += 2;
        if (ifid_instr !== 32'h8D0B_0000) begin bad++; $display("FAIL fr_instr1 got %h want %h", ifid_instr, 32'h8D0B_0000); end
        if (ifid_pc_plus4 !== 32'd8) begin bad++; $display("FAIL fr_pc4_1 got %h want %h", ifid_pc_plus4, 32'd8); end
        step(0, 0, 0, 0);
        total++;
        if (pc !== 32'd12) begin bad++; $display("FAIL fr_pc got %h want %h", pc, 32'd12); end
    endtask

    task automatic test_stall();
        logic [31:0] held;
        held = ifid_instr;
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        total += 2;
        if (pc !== 32'd12) begin bad++; $display("FAIL st_pc got %h want %h", pc, 32'd12); end
        if (ifid_instr !== held) begin bad++; $display("FAIL st_instr got %h want %h", ifid_instr, held); end
        step(0, 0, 0, 0);
        total += 2;
        if (ifid_instr !== mem[3]) begin bad++; $display("FAIL st_resume got %h want %h", ifid_instr, mem[3]); end
        if (pc !== 32'd16) begin bad++; $display("FAIL st_pc_resume got %h want %h", pc, 32'd16); end
    endtask

    task automatic test_redirect_flush();
        step(0, 1, 1, 32'h0000_0043);
        total += 3;
        if (ifid_valid !== 1'b0) begin bad++; $display("FAIL rf_valid got %b want 0", ifid_valid); end
        if (ifid_instr !== 32'd0) begin bad++; $display("FAIL rf_instr got %h want %h", ifid_instr, 32'd0); end
        if (im_addr !== 32'h40) begin bad++; $display("FAIL rf_im_addr got %h want %h", im_addr, 32'h40); end
        step(0, 0, 0, 0);
        total++;
        if (ifid_instr !== mem[16]) begin bad++; $display("FAIL rf_target got %h want %h", ifid_instr, mem[16]); end
    endtask

    task automatic test_redirect_stall();
        logic [31:0] hi, hp;
        hi = ifid_instr; hp = ifid_pc_plus4;
        step(1, 0, 1, 32'h20);
        total += 3;
        if (pc !== 32'h20) begin bad++; $display("FAIL rs_pc got %h want %h", pc, 32'h20); end
        if (ifid_instr !== hi) begin bad++; $display("FAIL rs_instr got %h want %h", ifid_instr, hi); end
        if (ifid_pc_plus4 !== hp) begin bad++; $display("FAIL rs_pc4 got %h want %h", ifid_pc_plus4, hp); end
    endtask

    task automatic test_wrap();
        step(0, 0, 1, 32'hFFFF_FFFF);
        step(0, 0, 0, 0);
        total += 2;
        if (pc !== 32'd0) begin bad++; $display("FAIL wr_pc got %h want %h", pc, 32'd0); end
        if (ifid_pc_plus4 !== 32'd0) begin bad++; $display("FAIL wr_pc4 got %h want %h", ifid_pc_plus4, 32'd0); end
    endtask

    task automatic test_reset_mid();
        step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        stall = 1'b1; pc_src = 1'b1; flush = 1'b0; pc_target = 32'h80;
        #2;
        rst_n = 1'b0;
        #1;
        total += 4;
        if (pc !== 32'd0) begin bad++; $display("FAIL rm_pc got %h want %h", pc, 32'd0); end
        if (im_addr !== 32'd0) begin bad++; $display("FAIL rm_im_addr got %h want %h", im_addr, 32'd0); end
        if (ifid_valid !== 1'b0) begin bad++; $display("FAIL rm_valid got %b want 0", ifid_valid); end
        if (ifid_instr !== 32'd0) begin bad++; $display("FAIL rm_instr got %h want %h", ifid_instr, 32'd0); end
        @(posedge clk);
        stall = 1'b0; pc_src = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 0, 0, 0);
        total++;
        if (ifid_instr !== 32'hAD0A_0008) begin bad++; $display("FAIL rm_refetch got %h want %h", ifid_instr, 32'hAD0A_0008); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 40; i++)
            step($urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0, $urandom);
    endtask

`ifdef IF_PERF_CNT_EN
    task automatic test_perf();
        test_reset();
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        total += 2;
        if (fetch_cnt !== 32'd5) begin bad++; $display("FAIL pf_fetch got %0d want 5", fetch_cnt); end
        if (stall_cnt !== 32'd2) begin bad++; $display("FAIL pf_stall got %0d want 2", stall_cnt); end
    endtask
`endif

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'(i) * 32'h9E37_79B9 + 32'h1357_9BDF;
        mem[0] = 32'hAD0A_0008;
        mem[1] = 32'h8D0B_0000;
        model_reset();
        test_reset();
        test_free_run();
        test_stall();
        test_redirect_flush();
        test_redirect_stall();
        test_wrap();
        test_reset_mid();
        test_back_to_back();
`ifdef IF_PERF_CNT_EN
        test_perf();
`endif
        #20;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
